// File: rtl/card_col_sequencer.sv
// card_col_sequencer
//   Sequences one punched-card read column by column. Column strobes load a
//   registered hold stage that drives the external card-code to EBCDIC
//   converter; the converter result is pushed into a small byte FIFO one
//   cycle later and delivered to the channel over a valid/ready handshake.
//   Tracks columns per card and reports bad-punch, overrun and done status.
//
//   Optional feature: define CCS_COLBIN_EN to enable column-binary mode,
//   in which the converter is bypassed and every column yields two bytes.
//   Without the macro i_colbin is accepted but has no effect.
module card_col_sequencer #(
    parameter int NCOLS      = 80,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_read,
    input  logic        i_colbin,
    input  logic        i_col_valid,
    input  logic [11:0] i_col_holes,
    output logic [11:0] o_conv_holes,
    input  logic [7:0]  i_conv_ebcdic,
    input  logic        i_conv_bad,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic [6:0]  o_col_count,
    output logic        o_err_bad,
    output logic        o_err_overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [6:0]       LAST_COL  = 7'(NCOLS);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    logic [1:0]       state_q, state_d;
    logic [11:0]      hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic [6:0]       col_cnt_q, col_cnt_d;
    logic             err_bad_q, err_bad_d;
    logic             err_ovr_q, err_ovr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [7:0]       fifo_mem [FIFO_DEPTH];

    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push_req;
    logic [7:0] push_byte;
    logic       push_bad;
    logic       do_push;
    logic       push_drop;
    logic       col_block;
    logic       stage_busy;

`ifdef CCS_COLBIN_EN
    logic       mode_q, mode_d;
    logic       lo_vld_q, lo_vld_d;
    logic [5:0] lo_q, lo_d;
`else
    logic unused_colbin;
    assign unused_colbin = i_colbin;
`endif

    // Select what the hold stage pushes this cycle and whether it can take a new column.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        push_req   = hold_vld_q;
        push_byte  = i_conv_ebcdic;
        push_bad   = hold_vld_q & i_conv_bad;
        col_block  = 1'b0;
        stage_busy = hold_vld_q;
`ifdef CCS_COLBIN_EN
        lo_vld_d   = 1'b0;
        lo_d       = lo_q;
        stage_busy = hold_vld_q | lo_vld_q;
        if (lo_vld_q) begin
            // Second byte of a binary column: low six rows.
            push_req  = 1'b1;
            push_byte = {2'b00, lo_q};
            push_bad  = 1'b0;
        end else if (hold_vld_q && mode_q) begin
            // First byte of a binary column: high six rows; the low half
            // is parked so the next cycle owns the push slot.
            push_byte = {2'b00, hold_q[11:6]};
            push_bad  = 1'b0;
            lo_vld_d  = 1'b1;
            lo_d      = hold_q[5:0];
            col_block = 1'b1;
        end
`endif
    end

    // FIFO occupancy, handshake and pointer update.
    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        fifo_full  = (fifo_cnt_q == FIFO_FULL);
        pop        = ~fifo_empty & i_ready;
        do_push    = push_req & (~fifo_full | pop);
        push_drop  = push_req & fifo_full & ~pop;
        wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(do_push) - CNT_W'(pop);
    end

    // Card sequencing: command start, column acceptance, drain and done.
    always_comb begin
        state_d    = state_q;
        col_cnt_d  = col_cnt_q;
        hold_d     = hold_q;
        hold_vld_d = 1'b0;
        err_bad_d  = err_bad_q | push_bad;
        err_ovr_d  = err_ovr_q | push_drop;
        o_done     = 1'b0;
`ifdef CCS_COLBIN_EN
        mode_d     = mode_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_read) begin
                    state_d   = ST_READ;
                    col_cnt_d = '0;
                    err_bad_d = 1'b0;
                    err_ovr_d = 1'b0;
`ifdef CCS_COLBIN_EN
                    mode_d    = i_colbin;
`endif
                end
            end
            ST_READ: begin
                if (i_col_valid) begin
                    if (col_block) begin
                        // Hold stage still owes a byte: the column is lost.
                        err_ovr_d = 1'b1;
                    end else begin
                        hold_d     = i_col_holes;
                        hold_vld_d = 1'b1;
                        col_cnt_d  = col_cnt_q + 7'd1;
                        if (col_cnt_d == LAST_COL) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!stage_busy && fifo_empty) begin
                    o_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            col_cnt_q  <= '0;
            err_bad_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            col_cnt_q  <= col_cnt_d;
            err_bad_q  <= err_bad_d;
            err_ovr_q  <= err_ovr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

`ifdef CCS_COLBIN_EN
    // Column-binary mode latch and parked low-half byte.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mode_q   <= 1'b0;
            lo_vld_q <= 1'b0;
            lo_q     <= '0;
        end else begin
            mode_q   <= mode_d;
            lo_vld_q <= lo_vld_d;
            lo_q     <= lo_d;
        end
    end
`endif

    // FIFO storage write port.
    // NOTE: the storage array is not reset; o_data is forced to zero while empty so stale entries never leak.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= push_byte;
        end
    end

    assign o_conv_holes  = hold_q;
    assign o_data        = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
    assign o_valid       = ~fifo_empty;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_col_count   = col_cnt_q;
    assign o_err_bad     = err_bad_q;
    assign o_err_overrun = err_ovr_q;

endmodule

// File: doc/card_col_sequencer.md
Name: card_col_sequencer

Overview:
- Sequences one card read, column by column, through the card-code to EBCDIC converter (12-row holes in, 8-bit EBCDIC plus bad-punch flag out).
- Accepts column strobes from the reader, drives the converter from a registered hold stage, and buffers the result bytes in a FIFO.
- Delivers bytes to the channel side over a valid/ready handshake.
- Counts columns per card and reports bad-code, overrun and done status. Sits between reader interface logic and channel data path.

Parameters:
- NCOLS, 80, columns per card; card ends when this many columns are accepted (1..127).
- FIFO_DEPTH, 8, output byte FIFO entries; power of two, >= 4.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_cmd_read  in  1  one-cycle pulse: start a card read.
- i_colbin  in  1  column-binary mode select, sampled at read start (only with CCS_COLBIN_EN).
- i_col_valid  in  1  one-cycle column strobe from reader.
- i_col_holes  in  12  hole image of column; bit11=row12 ... bit9=row0, bit8=row1 ... bit0=row9.
- o_conv_holes  out  12  registered hole image to converter.
- i_conv_ebcdic  in  8  converter EBCDIC result (combinational from o_conv_holes).
- i_conv_bad  in  1  converter invalid-punch flag.
- o_data  out  8  FIFO head byte.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data this cycle.
- o_busy  out  1  high in any state but IDLE.
- o_done  out  1  one-cycle pulse at end of card.
- o_col_count  out  7  columns accepted this card.
- o_err_bad  out  1  sticky: some column had an invalid punch.
- o_err_overrun  out  1  sticky: byte or column dropped.

Behaviour:
- Reset (async, i_reset low):
  - State IDLE; FIFO empty; hold stage empty.
  - o_conv_holes=0, o_data=0, o_valid=0, o_busy=0, o_done=0, o_col_count=0, errors=0.
  - Reset mid-card aborts the read; no o_done.
- States: IDLE -> READ -> DRAIN -> IDLE.
- IDLE:
  - i_cmd_read: clear o_col_count and both errors, latch mode, go READ.
  - i_col_valid ignored (not counted, no error).
- READ: i_col_valid loads the hold register (o_conv_holes) and increments o_col_count.
  - Latency: strobe in cycle N; hold loaded at end of N; converter output sampled and pushed at end of N+1; o_valid visible at N+2 if FIFO was empty.
  - EBCDIC mode accepts back-to-back strobes (one per cycle).
- DRAIN:
  - Entered when o_col_count reaches NCOLS.
  - Further i_col_valid ignored.
  - When hold stage is empty and FIFO is empty: o_done=1 for one cycle, go IDLE.
- i_cmd_read while o_busy: ignored.
- Push rules:
  - EBCDIC mode pushes i_conv_ebcdic.
  - If i_conv_bad, set o_err_bad; the byte is still pushed.
- Full FIFO:
  - Push with FIFO full and no simultaneous pop: byte dropped, o_err_overrun set, column still counted.
  - Simultaneous pop and push at full: both occur, no error.
- Output handshake:
  - Pop when o_valid & i_ready.
  - o_data stable while o_valid & !i_ready.
  - Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
- Errors stay set until the next accepted i_cmd_read, or reset.

Optional Feature:
- Macro CCS_COLBIN_EN.
- Defined:
  - If i_colbin is latched at read start, the converter is bypassed.
  - Each column pushes two bytes: first {2'b00,holes[11:6]}, then {2'b00,holes[5:0]} on the next cycle.
  - o_err_bad is never set in this mode.
  - An i_col_valid during the second-byte cycle sets o_err_overrun; that column is dropped and not counted.
- Not defined:
  - i_colbin port present but ignored; EBCDIC mode only.

Test Plan:
- Reset low mid-card (col_count=5, FIFO 3 bytes) -> all outputs 0 immediately, FIFO empty, no o_done after release.
- Start with NCOLS=3, columns 12'h200, 12'h100, 12'h800, i_ready=1 -> bytes 0xF0, 0xF1, 0x50 in order; first o_valid 2 cycles after first strobe; o_done one pulse; o_col_count=3; no errors.
- i_ready=0, FIFO_DEPTH=4, 5 back-to-back columns of 12'h200 -> 4 bytes held, o_err_overrun=1.
  - Then i_ready=1 -> exactly four 0xF0 bytes.
- Column 12'h0C0 with converter driving i_conv_bad=1 -> byte pushed, o_err_bad=1.
  - Error stays set through o_done; cleared by next i_cmd_read.
- i_cmd_read pulsed while busy, and i_col_valid pulsed in IDLE -> no state change, o_col_count unchanged, no error.
- With CCS_COLBIN_EN, i_colbin=1, column 12'hA05 -> bytes 0x28 then 0x05.
  - A strobe in the second-byte cycle -> o_err_overrun=1, count not incremented.
